// File: rtl/evo_gpio_pkg.sv
// Shared types and helpers for the GPIO port register block.
// CSR bus widths live here until the common constant package absorbs them.
package evo_gpio_pkg;

  localparam int unsigned CSR_AWIDTH    = 16;
  localparam int unsigned CSR_DWIDTH    = 32;
  localparam int unsigned GPIO_WIN_BITS = 4;

  typedef enum logic [3:0] {
    GPIO_OFF_DIR    = 4'd0,
    GPIO_OFF_DIRCLR = 4'd1,
    GPIO_OFF_DIRSET = 4'd2,
    GPIO_OFF_DIRTGL = 4'd3,
    GPIO_OFF_OUT    = 4'd4,
    GPIO_OFF_OUTCLR = 4'd5,
    GPIO_OFF_OUTSET = 4'd6,
    GPIO_OFF_OUTTGL = 4'd7,
    GPIO_OFF_IN     = 4'd8,
    GPIO_OFF_PCMSK  = 4'd9,
    GPIO_OFF_PCIFR  = 4'd10
  } gpio_off_e;

  // Low two offset bits select the alias within a DIR/OUT group.
  typedef enum logic [1:0] {
    GPIO_OP_WR  = 2'd0,
    GPIO_OP_CLR = 2'd1,
    GPIO_OP_SET = 2'd2,
    GPIO_OP_TGL = 2'd3
  } gpio_op_e;

  function automatic logic [31:0] apply_op(logic [31:0] value, logic [31:0] data, gpio_op_e op);
    case (op)
      GPIO_OP_CLR: return value & ~data;
      GPIO_OP_SET: return value | data;
      GPIO_OP_TGL: return value ^ data;
      default:     return data;
    endcase
  endfunction

endpackage

// File: rtl/evo_gpio_sync.sv
// Async-reset flop chain used to bring pad-side signals into the clk domain.
module evo_gpio_sync #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] stage_q [Stages];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < Stages; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int unsigned i = 1; i < Stages; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[Stages-1];

endmodule

// File: rtl/evo_gpio_port.sv
// Per-port GPIO register block: DIR/OUT with CLR/SET/TGL aliases, synchronised IN view and,
// when EVO_GPIO_PCINT_EN is defined, pin-change flags (PCMSK/PCIFR) with an irq output.
module evo_gpio_port
  import evo_gpio_pkg::*;
#(
  parameter int unsigned           DWIDTH        = 32,
  parameter logic [31:0]           PADMASK       = 32'hFFFFFFFF,
  parameter logic [CSR_AWIDTH-1:0] BASE_ADDR     = '0,
  parameter logic [31:0]           DIRX_RST_VAL  = 32'h0,
  parameter logic [31:0]           OUTX_RST_VAL  = 32'h0,
  parameter logic [31:0]           PCMSK_RST_VAL = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CSR_AWIDTH-1:0] csr_address,
  input  logic                  csr_read,
  input  logic                  csr_write,
  input  logic [CSR_DWIDTH-1:0] csr_writedata,
  output logic [CSR_DWIDTH-1:0] csr_readdata,
  output logic                  csr_readdatavalid,
  input  logic [DWIDTH-1:0]     port_in,
  output logic [DWIDTH-1:0]     port_out,
  output logic [DWIDTH-1:0]     port_dir,
  output logic                  irq
);

  localparam logic [31:0] WMASK = (DWIDTH >= 32) ? 32'hFFFFFFFF : ((32'h1 << DWIDTH) - 32'h1);
  localparam logic [31:0] MASK  = PADMASK & WMASK;

  logic        sel, wr, rd;
  logic [3:0]  off;
  logic [31:0] wdata, rd_val;
  logic [31:0] dir_q, dir_d, out_q, out_d;
  logic [31:0] in_val, pcmsk_q, pcifr_q;
  logic [DWIDTH-1:0] pin_sync;

  assign sel   = csr_address[CSR_AWIDTH-1:GPIO_WIN_BITS] == BASE_ADDR[CSR_AWIDTH-1:GPIO_WIN_BITS];
  assign off   = csr_address[GPIO_WIN_BITS-1:0];
  assign wr    = csr_write & sel;
  assign rd    = csr_read & sel;
  assign wdata = csr_writedata & MASK;

  evo_gpio_sync #(
    .Width (DWIDTH),
    .Stages(2)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (port_in),
    .q    (pin_sync)
  );

  always_comb begin
    in_val = '0;
    in_val[DWIDTH-1:0] = pin_sync;
    in_val = in_val & MASK;
  end

  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    if (wr && off[3:2] == 2'b00) dir_d = apply_op(dir_q, wdata, gpio_op_e'(off[1:0]));
    if (wr && off[3:2] == 2'b01) out_d = apply_op(out_q, wdata, gpio_op_e'(off[1:0]));
  end

`ifdef EVO_GPIO_PCINT_EN
  logic [31:0] in_dly, chg, pcmsk_d, pcifr_d;
  logic [1:0]  prime_q;
  logic        irq_q;

  evo_gpio_sync #(
    .Width (32),
    .Stages(1)
  ) u_dly (
    .clk  (clk),
    .reset(reset),
    .d    (in_val),
    .q    (in_dly)
  );

  // Edges are ignored until the synchroniser has flushed its reset zeros.
  always_comb begin
    chg     = (prime_q == 2'd3) ? ((in_val ^ in_dly) & pcmsk_q & MASK) : '0;
    pcmsk_d = (wr && off == GPIO_OFF_PCMSK) ? wdata : pcmsk_q;
    pcifr_d = pcifr_q;
    if (wr && off == GPIO_OFF_PCIFR) pcifr_d = pcifr_d & ~wdata;
    pcifr_d = pcifr_d | chg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_q <= 2'd0;
      pcmsk_q <= PCMSK_RST_VAL & MASK;
      pcifr_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
      pcmsk_q <= pcmsk_d;
      pcifr_q <= pcifr_d;
      irq_q   <= |pcifr_q;
    end
  end

  assign irq = irq_q;
`else
  assign pcmsk_q = '0;
  assign pcifr_q = '0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (off)
      GPIO_OFF_DIR:   rd_val = dir_q;
      GPIO_OFF_OUT:   rd_val = out_q;
      GPIO_OFF_IN:    rd_val = in_val;
      GPIO_OFF_PCMSK: rd_val = pcmsk_q;
      GPIO_OFF_PCIFR: rd_val = pcifr_q;
      default:        rd_val = '0;
    endcase
  end

  // Unselected reads return 0 so the interconnect can OR-reduce all ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q             <= DIRX_RST_VAL & MASK;
      out_q             <= OUTX_RST_VAL & MASK;
      csr_readdata      <= '0;
      csr_readdatavalid <= 1'b0;
    end else begin
      dir_q             <= dir_d;
      out_q             <= out_d;
      csr_readdatavalid <= rd;
      csr_readdata      <= rd ? rd_val : '0;
    end
  end

  assign port_dir = dir_q[DWIDTH-1:0];
  assign port_out = out_q[DWIDTH-1:0];

endmodule

// File: tb/tb_evo_gpio_port.sv
// Self-checking bench for evo_gpio_port: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model (handles EVO_GPIO_PCINT_EN on or off).
module tb_evo_gpio_port;
  import evo_gpio_pkg::*;

  localparam int unsigned           DW        = 26;
  localparam logic [31:0]           PM        = 32'h03803f73;
  localparam logic [31:0]           MK        = PM & 32'h03FFFFFF;
  localparam logic [CSR_AWIDTH-1:0] BA        = 16'h0040;
  localparam logic [31:0]           DIR_RST   = 32'hFFFFFFFF;
  localparam logic [31:0]           OUT_RST   = 32'h0;
  localparam logic [31:0]           PCMSK_RST = 32'h0;
`ifdef EVO_GPIO_PCINT_EN
  localparam bit PCINT = 1'b1;
`else
  localparam bit PCINT = 1'b0;
`endif

  logic                  clk, reset;
  logic [CSR_AWIDTH-1:0] csr_address;
  logic                  csr_read, csr_write;
  logic [31:0]           csr_writedata, csr_readdata;
  logic                  csr_readdatavalid;
  logic [DW-1:0]         port_in, port_out, port_dir;
  logic                  irq;

  evo_gpio_port #(
    .DWIDTH       (DW),
    .PADMASK      (PM),
    .BASE_ADDR    (BA),
    .DIRX_RST_VAL (DIR_RST),
    .OUTX_RST_VAL (OUT_RST),
    .PCMSK_RST_VAL(PCMSK_RST)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .csr_address      (csr_address),
    .csr_read         (csr_read),
    .csr_write        (csr_write),
    .csr_writedata    (csr_writedata),
    .csr_readdata     (csr_readdata),
    .csr_readdatavalid(csr_readdatavalid),
    .port_in          (port_in),
    .port_out         (port_out),
    .port_dir         (port_dir),
    .irq              (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_dir, m_out, m_pcmsk, m_pcifr, m_rdata;
  logic        m_irq, m_rvalid;
  logic [31:0] hist[$];  // pad samples taken since reset release, newest last, at most 3
  logic        m_hit;
  logic [3:0]  m_off;
  logic [31:0] m_wd;

  assign m_hit = csr_address[CSR_AWIDTH-1:4] == BA[CSR_AWIDTH-1:4];
  assign m_off = csr_address[3:0];
  assign m_wd  = csr_writedata & MK;

  // IN shows the pad as sampled two edges ago.
  function automatic logic [31:0] model_in();
    return (hist.size() >= 2) ? hist[hist.size()-2] : 32'h0;
  endfunction

  // A change only counts when both compared samples were taken after reset release.
  function automatic logic [31:0] model_chg();
    if (!PCINT || hist.size() < 3) return 32'h0;
    return (hist[hist.size()-2] ^ hist[hist.size()-3]) & m_pcmsk & MK;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] o);
    case (o)
      4'd0:    return m_dir;
      4'd4:    return m_out;
      4'd8:    return model_in();
      4'd9:    return PCINT ? m_pcmsk : 32'h0;
      4'd10:   return PCINT ? m_pcifr : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_op(input logic [31:0] cur, input logic [1:0] op,
                                           input logic [31:0] d);
    case (op)
      2'd0:    return d;
      2'd1:    return cur & ~d;
      2'd2:    return cur | d;
      default: return cur ^ d;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_dir    <= DIR_RST & MK;
      m_out    <= OUT_RST & MK;
      m_pcmsk  <= PCINT ? (PCMSK_RST & MK) : 32'h0;
      m_pcifr  <= 32'h0;
      m_irq    <= 1'b0;
      m_rvalid <= 1'b0;
      m_rdata  <= 32'h0;
      hist.delete();
    end else begin
      m_rvalid <= csr_read && m_hit;
      m_rdata  <= (csr_read && m_hit) ? model_read(m_off) : 32'h0;
      if (csr_write && m_hit) begin
        if (m_off < 4'd4) m_dir <= model_op(m_dir, m_off[1:0], m_wd);
        else if (m_off < 4'd8) m_out <= model_op(m_out, m_off[1:0], m_wd);
        else if (m_off == 4'd9 && PCINT) m_pcmsk <= m_wd;
      end
      m_pcifr <= PCINT ? ((m_pcifr & ~((csr_write && m_hit && m_off == 4'd10) ? m_wd : 32'h0))
                          | model_chg()) : 32'h0;
      m_irq   <= PCINT && (m_pcifr != 32'h0);
      hist.push_back(32'(port_in) & MK);
      if (hist.size() > 3) hist.pop_front();
    end
  end

  always @(negedge clk) begin
    check("port_dir", 32'(port_dir), m_dir);
    check("port_out", 32'(port_out), m_out);
    check("irq", 32'(irq), 32'(m_irq));
    check("readdatavalid", 32'(csr_readdatavalid), 32'(m_rvalid));
    check("readdata", csr_readdata, m_rdata);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [CSR_AWIDTH-1:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    step();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [CSR_AWIDTH-1:0] a, output logic [31:0] d, output logic v);
    csr_address = a;
    csr_read    = 1'b1;
    step();
    csr_read = 1'b0;
    d = csr_readdata;
    v = csr_readdatavalid;
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      csr_read      = ($urandom_range(0, 2) == 0);
      csr_write     = ($urandom_range(0, 2) == 0);
      csr_writedata = $urandom;
      csr_address   = BA + CSR_AWIDTH'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) csr_address = csr_address + 16'h0010;
      if ($urandom_range(0, 3) == 0) port_in = port_in ^ DW'($urandom);
      step();
    end
    csr_read  = 1'b0;
    csr_write = 1'b0;
  endtask

  initial begin : main
    logic [31:0] d;
    logic        v;
    reset = 1'b1;
    csr_address = '0;
    csr_read = 1'b0;
    csr_write = 1'b0;
    csr_writedata = '0;
    port_in = '1;
    repeat (3) step();
    check("rst_port_dir", 32'(port_dir), 32'h03803f73);
    check("rst_port_out", 32'(port_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rvalid", 32'(csr_readdatavalid), 32'h0);
    reset = 1'b0;

    // Pads high through reset must not produce flags.
    for (int i = 0; i < 20; i++) begin
      step();
      check("prime_irq", 32'(irq), 32'h0);
    end
    csr_rd(BA + 16'd10, d, v);
    check("prime_pcifr", d, 32'h0);

    csr_rd(BA + 16'd0, d, v);
    check("rd_dir_valid", 32'(v), 32'h1);
    check("rd_dir", d, 32'h03803f73);
    step();
    check("rd_valid_one_cycle", 32'(csr_readdatavalid), 32'h0);
    csr_rd(BA + 16'd4, d, v);
    check("rd_out", d, 32'h0);
    csr_rd(BA + 16'd9, d, v);
    check("rd_pcmsk", d, 32'h0);

    csr_wr(BA + 16'd0, 32'h000000FF);
    csr_wr(BA + 16'd1, 32'h0000000F);
    csr_wr(BA + 16'd2, 32'h03000000);
    csr_wr(BA + 16'd3, 32'h00000011);
    csr_rd(BA + 16'd0, d, v);
    check("dir_ops", d, 32'h03000061);
    check("port_dir_ops", 32'(port_dir), 32'h03000061);

    // Pin-change on bit 0: fall, clear, then timed rise.
    csr_wr(BA + 16'd9, 32'h1);
    csr_rd(BA + 16'd9, d, v);
    check("pcmsk_wr", d, PCINT ? 32'h1 : 32'h0);
    port_in[0] = 1'b0;
    repeat (6) step();
    csr_wr(BA + 16'd10, 32'h1);
    repeat (2) step();
    check("irq_cleared_pre", 32'(irq), 32'h0);
    port_in[0] = 1'b1;
    repeat (3) step();
    check("irq_t3", 32'(irq), 32'h0);
    step();
    check("irq_t4", 32'(irq), PCINT ? 32'h1 : 32'h0);
    csr_rd(BA + 16'd10, d, v);
    check("pcifr_set", d, PCINT ? 32'h1 : 32'h0);
    csr_wr(BA + 16'd10, 32'h1);
    check("irq_hold", 32'(irq), PCINT ? 32'h1 : 32'h0);
    step();
    check("irq_clr", 32'(irq), 32'h0);

    // Clear write lands on the same edge as a new change: the flag must survive.
    port_in[0] = 1'b0;
    repeat (2) step();
    csr_wr(BA + 16'd10, 32'h1);
    csr_rd(BA + 16'd10, d, v);
    check("set_wins", d, PCINT ? 32'h1 : 32'h0);
    csr_wr(BA + 16'd10, 32'hFFFFFFFF);

    csr_rd(BA + 16'd16, d, v);
    check("unsel_valid", 32'(v), 32'h0);
    check("unsel_data", d, 32'h0);
    csr_rd(BA + 16'd12, d, v);
    check("unmapped_valid", 32'(v), 32'h1);
    check("unmapped_data", d, 32'h0);

    rand_phase(1500);

    // Reset arriving while read data is on the bus drops it.
    csr_address = BA;
    csr_read = 1'b1;
    step();
    csr_read = 1'b0;
    check("rvalid_pre_rst", 32'(csr_readdatavalid), 32'h1);
    reset = 1'b1;
    #1;
    check("rvalid_dropped", 32'(csr_readdatavalid), 32'h0);
    repeat (2) step();
    reset = 1'b0;

    rand_phase(500);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
